// File: rtl/riscv_run_controller.sv
// Run/halt/single-step sequencer for the single-cycle RV32I computer.
// Define RUN_CTRL_BREAKPOINT_EN to build the PC breakpoint and BREAK state.
module riscv_run_controller #(
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [STEP_W-1:0] step_count,
  input  logic              bp_valid,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              halted,
  output logic [STEP_W-1:0] steps_left,
  output logic [CNT_W-1:0]  instr_count,
  output logic              bp_hit
);

  localparam logic [1:0] ST_HALTED = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_STEP   = 2'b10;
  localparam logic [1:0] ST_BREAK  = 2'b11;

  logic              bp_skip;
  logic              bp_stop;
  logic              active;
  logic              stopped;
  logic [1:0]        state_d;
  logic [STEP_W-1:0] steps_d;
  logic [STEP_W-1:0] step_load;
  logic              hit_d;
  logic              skip_d;

`ifdef RUN_CTRL_BREAKPOINT_EN
  // Stop before the matching PC executes, unless just resumed from it.
  assign bp_stop = bp_valid && (pc == bp_addr) && !bp_skip;
`else
  logic unused_bp;
  assign bp_stop   = 1'b0;
  assign unused_bp = ^{bp_valid, bp_addr, pc, bp_skip};
`endif

  assign active  = (state == ST_RUN) || (state == ST_STEP);
  assign stopped = (state == ST_HALTED) || (state == ST_BREAK);
  assign cpu_en  = active && !bp_stop;
  assign halted  = stopped;

  assign step_load = (step_count == '0) ? STEP_W'(1) : step_count;

  // Next-state: halt, then breakpoint, then per-state commands.
  always_comb begin
    state_d = state;
    steps_d = steps_left;
    hit_d   = bp_hit;
    skip_d  = cpu_en ? 1'b0 : bp_skip;
    if (halt_req) begin
      state_d = ST_HALTED;
      steps_d = '0;
    end else if (active && bp_stop) begin
      state_d = ST_BREAK;
      hit_d   = 1'b1;
    end else if (stopped) begin
      if (step_req) begin
        state_d = ST_STEP;
        steps_d = step_load;
        hit_d   = 1'b0;
        skip_d  = (state == ST_BREAK);
      end else if (run_req) begin
        state_d = ST_RUN;
        hit_d   = 1'b0;
        skip_d  = (state == ST_BREAK);
      end
    end else if (state == ST_STEP) begin
      if (run_req) begin
        state_d = ST_RUN;
        steps_d = '0;
        hit_d   = 1'b0;
      end else if (steps_left <= STEP_W'(1)) begin
        state_d = ST_HALTED;
        steps_d = '0;
      end else begin
        steps_d = steps_left - STEP_W'(1);
      end
    end
  end

  // Control registers and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_HALTED;
      steps_left  <= '0;
      instr_count <= '0;
      bp_hit      <= 1'b0;
      bp_skip     <= 1'b0;
    end else begin
      state      <= state_d;
      steps_left <= steps_d;
      bp_hit     <= hit_d;
      bp_skip    <= skip_d;
      if (cpu_en)
        instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_riscv_run_controller.sv
// Directed bench for riscv_run_controller.
// Vector table plus breakpoint sequences.
module tb_riscv_run_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic [15:0] step_count = '0;
  logic        bp_valid = 1'b0;
  logic [31:0] bp_addr = '0;
  logic [31:0] pc = '0;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] steps_left;
  logic [31:0] instr_count;
  logic        bp_hit;

  int checks = 0;
  int errors = 0;

  riscv_run_controller #(.STEP_W(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .run_req(run_req), .halt_req(halt_req),
    .step_req(step_req), .step_count(step_count),
    .bp_valid(bp_valid), .bp_addr(bp_addr), .pc(pc),
    .cpu_en(cpu_en), .state(state), .halted(halted),
    .steps_left(steps_left), .instr_count(instr_count),
    .bp_hit(bp_hit)
  );

  always #5 clk = ~clk;

  // Datapath PC stand-in: +4 per enabled cycle.
  always @(posedge clk) begin
    if (reset) pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  typedef struct {
    logic        rst, run, halt, step;
    logic [15:0] cnt;
    logic [1:0]  st;
    logic        en;
    logic [15:0] sl;
    logic [31:0] ic;
  } vec_t;

  vec_t vt[27];

  function automatic vec_t mk(
    input logic r, input logic ru, input logic h,
    input logic s, input int c, input int st,
    input logic en, input int sl, input int ic);
    vec_t v;
    v.rst = r; v.run = ru; v.halt = h; v.step = s;
    v.cnt = 16'(c); v.st = 2'(st); v.en = en;
    v.sl = 16'(sl); v.ic = 32'(ic);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    //          rst run hlt stp cnt st en sl ic
    vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 1, 3, 2, 1, 3, 0);
    vt[4]  = mk(0, 0, 0, 0, 0, 2, 1, 2, 1);
    vt[5]  = mk(0, 0, 0, 0, 0, 2, 1, 1, 2);
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3);
    vt[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3);
    vt[8]  = mk(0, 0, 0, 1, 0, 2, 1, 1, 3);
    vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 4);
    vt[10] = mk(0, 1, 0, 0, 0, 1, 1, 0, 4);
    vt[11] = mk(0, 0, 0, 0, 0, 1, 1, 0, 5);
    vt[12] = mk(0, 0, 0, 1, 7, 1, 1, 0, 6);
    vt[13] = mk(0, 1, 1, 1, 4, 0, 0, 0, 7);
    vt[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7);
    vt[15] = mk(0, 0, 0, 1, 5, 2, 1, 5, 7);
    vt[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[17] = mk(0, 0, 0, 1, 4, 2, 1, 4, 0);
    vt[18] = mk(0, 1, 0, 0, 0, 1, 1, 0, 1);
    vt[19] = mk(0, 0, 1, 0, 0, 0, 0, 0, 2);
    vt[20] = mk(0, 0, 0, 1, 2, 2, 1, 2, 2);
    vt[21] = mk(0, 0, 1, 0, 0, 0, 0, 0, 3);
    vt[22] = mk(0, 1, 0, 1, 2, 2, 1, 2, 3);
    vt[23] = mk(0, 0, 0, 0, 0, 2, 1, 1, 4);
    vt[24] = mk(0, 1, 0, 0, 0, 1, 1, 0, 5);
    vt[25] = mk(0, 1, 0, 0, 0, 1, 1, 0, 6);
    vt[26] = mk(0, 0, 1, 0, 0, 0, 0, 0, 7);

    for (int i = 0; i < 27; i++) begin
      reset      = vt[i].rst;
      run_req    = vt[i].run;
      halt_req   = vt[i].halt;
      step_req   = vt[i].step;
      step_count = vt[i].cnt;
      tick();
      chk($sformatf("v%0d.state", i), 32'(state), 32'(vt[i].st));
      chk($sformatf("v%0d.cpu_en", i), 32'(cpu_en), 32'(vt[i].en));
      chk($sformatf("v%0d.halted", i), 32'(halted),
          32'(vt[i].st == 2'b00 || vt[i].st == 2'b11));
      chk($sformatf("v%0d.steps", i), 32'(steps_left), 32'(vt[i].sl));
      chk($sformatf("v%0d.icount", i), instr_count, vt[i].ic);
    end
    reset = 1'b0; run_req = 1'b0; halt_req = 1'b0;
    step_req = 1'b0; step_count = '0;

`ifdef RUN_CTRL_BREAKPOINT_EN
    // Free-run into breakpoint at 0x10, then resume through it.
    do_reset();
    bp_valid = 1'b1; bp_addr = 32'h10;
    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("bp.run_pc", pc, 32'h0);
    repeat (4) tick();
    chk("bp.at_pc", pc, 32'h10);
    chk("bp.en_off", 32'(cpu_en), 32'd0);
    chk("bp.still_run", 32'(state), 32'd1);
    tick();
    chk("bp.state", 32'(state), 32'd3);
    chk("bp.hit", 32'(bp_hit), 32'd1);
    chk("bp.icount", instr_count, 32'd4);
    chk("bp.halted", 32'(halted), 32'd1);
    chk("bp.hold_pc", pc, 32'h10);
    run_req = 1'b1; tick(); run_req = 1'b0;
    chk("bp.resume_st", 32'(state), 32'd1);
    chk("bp.hit_clr", 32'(bp_hit), 32'd0);
    chk("bp.skip_en", 32'(cpu_en), 32'd1);
    tick();
    chk("bp.past_pc", pc, 32'h14);
    chk("bp.past_ic", instr_count, 32'd5);
    halt_req = 1'b1; tick(); halt_req = 1'b0;

    // Halt in the same cycle as a breakpoint match.
    do_reset();
    bp_addr = 32'h8;
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (2) tick();
    chk("bph.match_en", 32'(cpu_en), 32'd0);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("bph.state", 32'(state), 32'd0);
    chk("bph.hit", 32'(bp_hit), 32'd0);

    // Breakpoint on the last step keeps steps_left.
    do_reset();
    step_req = 1'b1; step_count = 16'd3; tick();
    step_req = 1'b0;
    repeat (2) tick();
    chk("bps.pc", pc, 32'h8);
    chk("bps.sl1", 32'(steps_left), 32'd1);
    tick();
    chk("bps.state", 32'(state), 32'd3);
    chk("bps.sl_hold", 32'(steps_left), 32'd1);
    chk("bps.hit", 32'(bp_hit), 32'd1);
    step_req = 1'b1; step_count = 16'd1; tick();
    step_req = 1'b0;
    chk("bps.resume", 32'(cpu_en), 32'd1);
    tick();
    chk("bps.done_st", 32'(state), 32'd0);
    chk("bps.done_pc", pc, 32'hc);
    chk("bps.done_sl", 32'(steps_left), 32'd0);
`else
    // Breakpoint inputs have no effect in this build.
    do_reset();
    bp_valid = 1'b1; bp_addr = 32'h8;
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (3) tick();
    chk("nobp.state", 32'(state), 32'd1);
    chk("nobp.pc", pc, 32'hc);
    chk("nobp.icount", instr_count, 32'd3);
    chk("nobp.hit", 32'(bp_hit), 32'd0);
    chk("nobp.en", 32'(cpu_en), 32'd1);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("nobp.halt", 32'(state), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
